// File: rtl/ds_decode_pkg.sv
// rtl/ds_decode_pkg.sv - shared opcode, XO and operation encodings for DS-format decode
package ds_decode_pkg;

  localparam logic [5:0] OPC_LOAD  = 6'd58;
  localparam logic [5:0] OPC_STORE = 6'd62;

  localparam logic [1:0] XO_0 = 2'd0;
  localparam logic [1:0] XO_1 = 2'd1;
  localparam logic [1:0] XO_2 = 2'd2;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_LD   = 3'd0,
    OP_LDU  = 3'd1,
    OP_LWA  = 3'd2,
    OP_STD  = 3'd3,
    OP_STDU = 3'd4,
    OP_STQ  = 3'd5
  } op_e;

endpackage

// File: rtl/ds_decode_if.sv
// rtl/ds_decode_if.sv - instruction-in / decoded-payload-out handshake bundle
interface ds_decode_if
  import ds_decode_pkg::*;
#(
  parameter int regWidth         = 5,
  parameter int instructionWidth = 32,
  parameter int dataWidth        = 64,
  parameter int counterWidth     = 32
) ();

  logic                        valid_i;
  logic                        ready_o;
  logic [0:instructionWidth-1] instruction_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [0:regWidth-1]         reg1_o;
  logic [0:regWidth-1]         reg2_o;
  logic                        reg2ValOrZero_o;
  logic [0:dataWidth-1]        imm_o;
  logic [0:OP_WIDTH-1]         op_o;
  logic                        isStore_o;
  logic                        isUpdate_o;
  logic                        illegal_o;
  logic [0:counterWidth-1]     decodeCount_o;
  logic [0:counterWidth-1]     illegalCount_o;

  modport slave (
    input  valid_i, instruction_i, ready_i,
    output ready_o, valid_o, reg1_o, reg2_o, reg2ValOrZero_o, imm_o, op_o,
           isStore_o, isUpdate_o, illegal_o, decodeCount_o, illegalCount_o
  );

  modport master (
    output valid_i, instruction_i, ready_i,
    input  ready_o, valid_o, reg1_o, reg2_o, reg2ValOrZero_o, imm_o, op_o,
           isStore_o, isUpdate_o, illegal_o, decodeCount_o, illegalCount_o
  );

endinterface

// File: rtl/ds_decode_comb.sv
// rtl/ds_decode_comb.sv - pure combinational DS-form classifier
module ds_decode_comb
  import ds_decode_pkg::*;
#(
  parameter int opcodeWidth      = 6,
  parameter int regWidth         = 5,
  parameter int instructionWidth = 32,
  parameter int dataWidth        = 64
) (
  input  logic [0:instructionWidth-1] instruction_i,
  output logic [0:regWidth-1]         reg1_o,
  output logic [0:regWidth-1]         reg2_o,
  output logic                        reg2ValOrZero_o,
  output logic [0:dataWidth-1]        imm_o,
  output op_e                         op_o,
  output logic                        isStore_o,
  output logic                        isUpdate_o,
  output logic                        legal_o
);

  logic [0:opcodeWidth-1] opcode;
  logic [0:13]            ds;
  logic [0:1]             xo;

  assign opcode = instruction_i[0:opcodeWidth-1];
  assign reg1_o = instruction_i[opcodeWidth +: regWidth];
  assign reg2_o = instruction_i[opcodeWidth+regWidth +: regWidth];
  assign ds     = instruction_i[16:29];
  assign xo     = instruction_i[30:31];

  // The low two displacement bits are implied zero; sign comes from DS[16].
  assign imm_o = {{(dataWidth-16){ds[0]}}, ds, 2'b00};

  always_comb begin
    op_o    = OP_LD;
    legal_o = 1'b0;
    if (opcode == OPC_LOAD) begin
      case (xo)
        XO_0: begin op_o = OP_LD;  legal_o = 1'b1; end
        XO_1: begin op_o = OP_LDU; legal_o = (reg2_o != '0) && (reg2_o != reg1_o); end
        XO_2: begin op_o = OP_LWA; legal_o = 1'b1; end
        default: ;
      endcase
    end else if (opcode == OPC_STORE) begin
      case (xo)
        XO_0: begin op_o = OP_STD;  legal_o = 1'b1; end
        XO_1: begin op_o = OP_STDU; legal_o = (reg2_o != '0); end
        XO_2: begin op_o = OP_STQ;  legal_o = !reg1_o[regWidth-1]; end
        default: ;
      endcase
    end
  end

  assign isStore_o       = (op_o == OP_STD) || (op_o == OP_STDU) || (op_o == OP_STQ);
  assign isUpdate_o      = (op_o == OP_LDU) || (op_o == OP_STDU);
  assign reg2ValOrZero_o = !isUpdate_o;

endmodule

// File: rtl/ds_decode_stage.sv
// rtl/ds_decode_stage.sv - handshaked DS decode stage with output register, skid slot and counters
module ds_decode_stage
  import ds_decode_pkg::*;
#(
  parameter int opcodeWidth      = 6,
  parameter int regWidth         = 5,
  parameter int instructionWidth = 32,
  parameter int dataWidth        = 64,
  parameter int counterWidth     = 32
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        flush_i,
  ds_decode_if.slave  bus
);

  localparam int PW = 2*regWidth + 1 + dataWidth + OP_WIDTH + 2;
  localparam logic [0:counterWidth-1] CNT_ONE = 1;

  logic [0:regWidth-1]  dec_reg1, dec_reg2;
  logic                 dec_r2z, dec_store, dec_update, dec_legal;
  logic [0:dataWidth-1] dec_imm;
  op_e                  dec_op;
  logic [0:PW-1]        dec_payload;

  logic [0:PW-1]           out_q, out_d, skid_q, skid_d;
  logic                    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic                    illegal_q, illegal_d;
  logic [0:counterWidth-1] decode_cnt_q, decode_cnt_d, illegal_cnt_q, illegal_cnt_d;
  logic                    accept, drain;

  ds_decode_comb #(
    .opcodeWidth      (opcodeWidth),
    .regWidth         (regWidth),
    .instructionWidth (instructionWidth),
    .dataWidth        (dataWidth)
  ) u_comb (
    .instruction_i   (bus.instruction_i),
    .reg1_o          (dec_reg1),
    .reg2_o          (dec_reg2),
    .reg2ValOrZero_o (dec_r2z),
    .imm_o           (dec_imm),
    .op_o            (dec_op),
    .isStore_o       (dec_store),
    .isUpdate_o      (dec_update),
    .legal_o         (dec_legal)
  );

  assign dec_payload = {dec_reg1, dec_reg2, dec_r2z, dec_imm, dec_op, dec_store, dec_update};
  assign accept      = bus.valid_i && !skid_valid_q;
  assign drain       = out_valid_q && bus.ready_i;

  always_comb begin
    out_valid_d   = out_valid_q;
    skid_valid_d  = skid_valid_q;
    out_d         = out_q;
    skid_d        = skid_q;
    illegal_d     = 1'b0;
    decode_cnt_d  = decode_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (accept && dec_legal) decode_cnt_d = decode_cnt_q + CNT_ONE;
      if (accept && !dec_legal) begin
        illegal_cnt_d = illegal_cnt_q + CNT_ONE;
        illegal_d     = 1'b1;
      end
      // A full skid blocks intake, so only its transfer to the output can occur.
      if (skid_valid_q) begin
        if (drain) begin
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end
      end else if (accept && dec_legal) begin
        if (!out_valid_q || drain) begin
          out_d       = dec_payload;
          out_valid_d = 1'b1;
        end else begin
          skid_d       = dec_payload;
          skid_valid_d = 1'b1;
        end
      end else if (drain) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_q         <= '0;
      skid_q        <= '0;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      illegal_q     <= 1'b0;
      decode_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      out_q         <= out_d;
      skid_q        <= skid_d;
      out_valid_q   <= out_valid_d;
      skid_valid_q  <= skid_valid_d;
      illegal_q     <= illegal_d;
      decode_cnt_q  <= decode_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.ready_o        = !skid_valid_q;
  assign bus.valid_o        = out_valid_q;
  assign bus.illegal_o      = illegal_q;
  assign bus.decodeCount_o  = decode_cnt_q;
  assign bus.illegalCount_o = illegal_cnt_q;
  assign {bus.reg1_o, bus.reg2_o, bus.reg2ValOrZero_o, bus.imm_o, bus.op_o,
          bus.isStore_o, bus.isUpdate_o} = out_q;

endmodule

// File: tb/tb_ds_decode_stage.sv
// tb/tb_ds_decode_stage.sv - vector table plus scoreboard bench for ds_decode_stage
module tb_ds_decode_stage;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  bit   rand_rdy = 1'b0;

  always #5 clock = ~clock;

  ds_decode_if bus ();

  ds_decode_stage dut (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .flush_i   (flush),
    .bus       (bus)
  );

  typedef struct {
    logic [31:0] instr;
    bit          legal;
    logic [2:0]  op;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] imm;
    bit          st;
    bit          up;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_dec = 0;
  int   exp_ill = 0;
  bit   ill_pend = 1'b0;
  int   cur = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int opc, input int rt, input int ra,
                                      input int ds, input int xo);
    return {opc[5:0], rt[4:0], ra[4:0], ds[13:0], xo[1:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input bit lg, input int op,
                              input int r1, input int r2, input logic [63:0] imm,
                              input bit st, input bit up);
    vec_t v;
    v.instr = i; v.legal = lg; v.op = op[2:0]; v.r1 = r1[4:0]; v.r2 = r2[4:0];
    v.imm = imm; v.st = st; v.up = up;
    return v;
  endfunction

  // Scoreboard: outputs are popped at the transfer cycle, accepts pushed the same cycle.
  always @(negedge clock) begin
    vec_t e;
    if (!reset_n) begin
      sb.delete();
      exp_dec = 0;
      exp_ill = 0;
      ill_pend = 1'b0;
    end else begin
      check("illegal_o_pulse", bus.illegal_o, ill_pend);
      ill_pend = 1'b0;
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_valid_o", bus.valid_o, 0);
        end else begin
          e = sb.pop_front();
          check("out_op", bus.op_o, e.op);
          check("out_reg1", bus.reg1_o, e.r1);
          check("out_reg2", bus.reg2_o, e.r2);
          check("out_imm", bus.imm_o, e.imm);
          check("out_flags", {bus.isStore_o, bus.isUpdate_o, bus.reg2ValOrZero_o},
                {e.st, e.up, !e.up});
        end
      end
      if (flush) begin
        sb.delete();
      end else if (bus.valid_i && bus.ready_o) begin
        if (vecs[cur].legal) begin
          sb.push_back(vecs[cur]);
          exp_dec++;
        end else begin
          exp_ill++;
          ill_pend = 1'b1;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (rand_rdy) begin
      #2;
      bus.ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input int idx);
    int n;
    n = 0;
    cur = idx;
    bus.instruction_i = vecs[idx].instr;
    bus.valid_i = 1'b1;
    @(negedge clock);
    while (!bus.ready_o && n < 50) begin
      n++;
      @(negedge clock);
    end
    check("send_accept", bus.ready_o, 1);
    @(posedge clock);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_decode_count"}, bus.decodeCount_o, exp_dec);
    check({tag, "_illegal_count"}, bus.illegalCount_o, exp_ill);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int b_dec, b_ill;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.instruction_i = '0;

    vecs[0]  = mk(32'hE8610008, 1, 0, 3, 1, 64'h8, 0, 0);
    vecs[1]  = mk(enc(62, 5, 2, 'h3FFF, 0), 1, 3, 5, 2, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
    vecs[2]  = mk(enc(58, 4, 7, 4, 1), 1, 1, 4, 7, 64'h10, 0, 1);
    vecs[3]  = mk(enc(58, 9, 10, 'h3FFF, 2), 1, 2, 9, 10, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    vecs[4]  = mk(enc(62, 6, 8, 'h40, 1), 1, 4, 6, 8, 64'h100, 1, 1);
    vecs[5]  = mk(enc(62, 4, 3, 2, 2), 1, 5, 4, 3, 64'h8, 1, 0);
    vecs[6]  = mk(enc(58, 31, 0, 'h1FFF, 0), 1, 0, 31, 0, 64'h7FFC, 0, 0);
    vecs[7]  = mk(enc(58, 4, 0, 0, 1), 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(enc(62, 5, 3, 2, 2), 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(enc(31, 3, 4, 0, 0), 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(enc(58, 5, 5, 1, 1), 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(enc(62, 6, 0, 1, 1), 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(enc(58, 1, 2, 0, 3), 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(enc(62, 1, 2, 'h2000, 0), 1, 3, 1, 2, 64'hFFFF_FFFF_FFFF_8000, 1, 0);
    vecs[14] = mk(enc(62, 7, 7, 1, 1), 1, 4, 7, 7, 64'h4, 1, 1);

    @(posedge clock);
    #1;
    check("rst_valid_o", bus.valid_o, 0);
    check("rst_ready_o", bus.ready_o, 1);
    check("rst_illegal_o", bus.illegal_o, 0);
    check("rst_imm_o", bus.imm_o, 0);
    check("rst_regs", {bus.reg1_o, bus.reg2_o, bus.op_o}, 0);
    check("rst_counts", {bus.decodeCount_o, bus.illegalCount_o}, 0);
    reset_n = 1'b1;
    idle(1);

    // ld r3,8(r1): one-cycle latency
    bus.ready_i = 1'b1;
    send(0);
    @(negedge clock);
    check("ld_valid_o", bus.valid_o, 1);
    check("ld_reg2ValOrZero", bus.reg2ValOrZero_o, 1);
    check("ld_decode_count", bus.decodeCount_o, 1);
    idle(1);

    for (int i = 0; i < 15; i++) send(i);
    idle(3);
    check_counts("table");

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send($urandom_range(0, 14));
    rand_rdy = 1'b0;
    @(posedge clock);
    #3;
    bus.ready_i = 1'b1;
    idle(4);
    check_counts("random_ready");

    // Three illegal forms, separated so every pulse must be exactly one cycle.
    b_dec = exp_dec;
    b_ill = exp_ill;
    send(7); idle(1);
    send(8); idle(1);
    send(9); idle(2);
    check("trio_illegal_count", bus.illegalCount_o, b_ill + 3);
    check("trio_decode_count", bus.decodeCount_o, b_dec);

    // Back-pressure: LD, LDU fill output and skid; STD waits.
    bus.ready_i = 1'b0;
    send(0);
    send(2);
    cur = 1;
    bus.instruction_i = vecs[1].instr;
    bus.valid_i = 1'b1;
    @(negedge clock);
    check("bp_ready_low", bus.ready_o, 0);
    idle(1);
    @(negedge clock);
    check("bp_hold_valid", bus.valid_o, 1);
    check("bp_hold_reg1", bus.reg1_o, 3);
    check("bp_hold_imm", bus.imm_o, 64'h8);
    idle(1);
    bus.ready_i = 1'b1;
    @(negedge clock);
    check("bp_first_drain_ready", bus.ready_o, 0);
    idle(1);
    check("bp_ready_back", bus.ready_o, 1);
    send(1);
    idle(4);
    check_counts("backpressure");

    // Flush with output and skid full; illegal input offered alongside.
    bus.ready_i = 1'b0;
    send(0);
    send(3);
    b_dec = exp_dec;
    b_ill = exp_ill;
    cur = 9;
    bus.instruction_i = vecs[9].instr;
    bus.valid_i = 1'b1;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clock);
    check("flush_valid_o", bus.valid_o, 0);
    check("flush_ready_o", bus.ready_o, 1);
    idle(1);

    // Flush on an idle stage must discard a same-cycle legal and illegal offer.
    cur = 0;
    bus.instruction_i = vecs[0].instr;
    bus.valid_i = 1'b1;
    flush = 1'b1;
    idle(1);
    cur = 7;
    bus.instruction_i = vecs[7].instr;
    idle(1);
    flush = 1'b0;
    bus.valid_i = 1'b0;
    idle(2);
    check("flush_decode_count", bus.decodeCount_o, b_dec);
    check("flush_illegal_count", bus.illegalCount_o, b_ill);
    check("flush_no_output", bus.valid_o, 0);

    // Asynchronous reset mid-stall.
    send(0);
    send(2);
    idle(1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid_o", bus.valid_o, 0);
    check("arst_ready_o", bus.ready_o, 1);
    check("arst_illegal_o", bus.illegal_o, 0);
    check("arst_imm_o", bus.imm_o, 0);
    check("arst_regs", {bus.reg1_o, bus.reg2_o, bus.op_o, bus.isStore_o, bus.isUpdate_o}, 0);
    check("arst_counts", {bus.decodeCount_o, bus.illegalCount_o}, 0);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bus.ready_i = 1'b1;
    idle(1);
    send(0);
    idle(3);
    check("post_rst_decode_count", bus.decodeCount_o, 1);
    check_counts("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ds_decode_stage.md
# ds_decode_stage

Pipelined, back-pressurable decode stage for all integer DS-format instructions (primary opcodes 58 and 62). It replaces the single-cycle, unhandshaked DS decoder. It sits between fetch/issue and the load/store unit. It adds a valid/ready handshake with a 2-entry skid buffer, emits a fully formed sign-extended displacement, classifies the operation, rejects invalid instruction forms, and keeps decode/illegal counters.

## Interface
Parameters:
- opcodeWidth, 6, primary opcode field width
- regWidth, 5, register address width
- instructionWidth, 32, instruction width
- dataWidth, 64, width of `imm_o`; must be ≥ 16
- counterWidth, 32, width of each statistics counter

Ports (all vectors use big-endian `[0:N-1]` numbering):
- clock_i  in  1  single clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous pipeline flush
- valid_i  in  1  `instruction_i` is valid
- ready_o  out  1  stage can accept an instruction
- instruction_i  in  instructionWidth  instruction word
- valid_o  out  1  decoded payload is valid
- ready_i  in  1  downstream accepts the payload
- reg1_o  out  regWidth  RT/RS, bits 6:10
- reg2_o  out  regWidth  RA, bits 11:15
- reg2ValOrZero_o  out  1  when 1, RA=0 means literal zero
- imm_o  out  dataWidth  `sext({DS[16:29], 2'b00})`
- op_o  out  3  operation: 0 LD, 1 LDU, 2 LWA, 3 STD, 4 STDU, 5 STQ
- isStore_o  out  1  operation is a store
- isUpdate_o  out  1  operation writes back the EA to RA
- illegal_o  out  1  one-cycle pulse per rejected instruction
- decodeCount_o  out  counterWidth  count of legal instructions accepted
- illegalCount_o  out  counterWidth  count of illegal instructions accepted

## Operation
- Accept condition: `valid_i && ready_o`.
- Decode table:
  - opcode 58: XO 0 → LD, 1 → LDU, 2 → LWA.
  - opcode 62: XO 0 → STD, 1 → STDU, 2 → STQ.
  - `reg2ValOrZero_o = !isUpdate`.
- Illegal forms:
  - any other opcode, or XO 3;
  - LDU with RA=0 or RA=RT;
  - STDU with RA=0;
  - STQ with odd RS.
- An illegal instruction is still accepted (consumed). It is not forwarded. `illegal_o` pulses and `illegalCount_o` increments.
- A legal accepted instruction increments `decodeCount_o`.
- Both counters wrap modulo 2^counterWidth.
- Buffering uses an output register plus one skid register:
  - `ready_o = !skidValid`, taken directly from a flop.
  - A legal instruction goes to the output register if it is empty or is draining (`ready_i`) with the skid empty. Otherwise it goes to the skid.
  - When the output drains, the skid (if valid) moves into the output.
  - Strict program order is kept.
- Payload outputs hold their last value while `valid_o` = 0.
- Payload must stay stable while `valid_o && !ready_i`.
- flush_i:
  - Clears the output-valid and skid-valid bits.
  - Discards any same-cycle input: no count, no `illegal_o`.
  - `ready_o` = 1 on the next cycle.
  - Counters are not cleared.
- Simultaneous drain, accept and skid-valid cannot occur, because `ready_o` = 0 whenever the skid is valid.

## Timing
- Latency: 1 cycle from acceptance to `valid_o`, when unstalled.
- Throughput: 1 instruction per cycle while `ready_i` = 1.
- `illegal_o` rises the cycle after acceptance and lasts exactly 1 cycle.
- Counters update the cycle after acceptance.
- Reset, asynchronous and taking effect immediately:
  - `valid_o` = 0, `illegal_o` = 0;
  - all payload outputs = 0;
  - counters = 0;
  - skid empty, so `ready_o` = 1.
- Reset mid-operation drops all buffered instructions.
- With the output full, the skid full and `ready_i` = 0, `ready_o` = 0 until the first drain. The skid entry then moves to the output in that same cycle, and `ready_o` returns to 1 one cycle later.

## Structure
- Shared package `ds_decode_pkg` holds:
  - the opcode constants 58 and 62;
  - the XO constants;
  - the `op_o` enumeration and its 3-bit width.
- Sub-module `ds_decode_comb` is the pure combinational classifier. It maps an instruction to the payload plus a legal flag and is reused by both the skid and output paths.
- The top level holds the skid buffer, the handshake logic and the counters.

## Test plan
- `ld r3,8(r1)` (0xE8610008), `ready_i` = 1 → next cycle `valid_o` = 1, op 0, `reg1_o` = 3, `reg2_o` = 1, `imm_o` = 0x8, `reg2ValOrZero_o` = 1, `decodeCount_o` = 1.
- `std` with DS = 0x3FFF → `imm_o` = 0xFFFF_FFFF_FFFF_FFFC, op 3, `isStore_o` = 1.
- `ldu r4,0(r0)`, then `stq r5` (odd RS), then opcode 31 → no `valid_o`; three single-cycle `illegal_o` pulses; `illegalCount_o` = 3; `decodeCount_o` unchanged.
- Hold `ready_i` = 0 and offer LD, LDU, STD back-to-back:
  - LD and LDU are accepted; `ready_o` falls after the second accept.
  - Raise `ready_i` → outputs LD, LDU, STD in order, with no loss or duplicates.
- Output and skid full, assert `flush_i` with `valid_i` = 1 → next cycle `valid_o` = 0, `ready_o` = 1; the flushed input is not counted.
- Drop `reset_n_i` asynchronously mid-stall → all outputs 0 and `ready_o` = 1 immediately; normal decode resumes after release.
